// File: rtl/au_pkg.sv
// Shared arithmetic-unit definitions.
//
// Contents:
//   AU_WIDTH    - operand width of the AU buses (4)
//   DIV_STEPS   - quotient bits per division, one per sequential step (4)
//   div_state_t - control states of the sequential divider

package au_pkg;

  localparam int unsigned AU_WIDTH  = 4;
  localparam int unsigned DIV_STEPS = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_t;

endpackage

// File: rtl/restoring_divider_cell.sv
// One step of restoring division.
//
// The partial remainder is shifted left, the next dividend bit is brought in,
// and the divisor is subtracted when it fits.
//
// Ports:
//   partial_rem_in  in  WIDTH  remainder carried in from the previous step
//   dividend_bit    in  1      next dividend bit, MSB first
//   divisor         in  WIDTH  denominator
//   partial_rem_out out WIDTH  remainder after this step
//   quotient_bit    out 1      1 when the divisor was subtracted
//
// A zero divisor always "fits", so the quotient bits come out as all ones and
// the remainder accumulates the dividend unchanged.

module restoring_divider_cell #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] partial_rem_in,
  input  logic             dividend_bit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] partial_rem_out,
  output logic             quotient_bit
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] divisor_ext;
  logic [WIDTH:0] diff;

  assign shifted     = {partial_rem_in, dividend_bit};
  assign divisor_ext = {1'b0, divisor};
  assign diff        = shifted - divisor_ext;

  always_comb begin
    quotient_bit    = 1'b0;
    partial_rem_out = shifted[WIDTH-1:0];
    if (shifted >= divisor_ext) begin
      quotient_bit    = 1'b1;
      // The difference is below the divisor, so it always fits in WIDTH bits.
      partial_rem_out = diff[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/divider_seq_ctrl.sv
// Sequential 4-bit restoring divider: one quotient bit per clock using a
// single restoring_divider_cell, with valid/ready handshakes on both sides.
//
// Ports:
//   clk        in   1      clock, rising edge
//   rst_n      in   1      synchronous active-low reset
//   in_valid   in   1      operand pair valid
//   in_ready   out  1      operands accepted (IDLE only)
//   dividend   in   WIDTH  numerator, captured on input handshake
//   divisor    in   WIDTH  denominator, captured on input handshake
//   out_valid  out  1      result valid (DONE only)
//   out_ready  in   1      consumer accepts result
//   quotient   out  WIDTH  registered quotient
//   remainder  out  WIDTH  registered remainder
//   div_zero   out  1      captured divisor was zero
//   busy       out  1      RUN or DONE
//
// Build option: define DIV_ZERO_FASTPATH_EN to resolve a zero divisor after a
// single cycle instead of running the four division steps. The result
// (quotient all ones, remainder = dividend, div_zero set) is the same either way.

module divider_seq_ctrl
  import au_pkg::*;
#(
  parameter int unsigned WIDTH = AU_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero,
  output logic             busy
);

  localparam int unsigned CntW = $clog2(WIDTH);

  div_state_t       state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] dividend_q, dividend_d;
  logic [WIDTH-1:0] divisor_q, divisor_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic             div_zero_q, div_zero_d;

  logic [WIDTH-1:0] cell_rem;
  logic             cell_qbit;

  restoring_divider_cell #(
    .WIDTH (WIDTH)
  ) u_cell (
    .partial_rem_in  (rem_q),
    .dividend_bit    (dividend_q[cnt_q]),
    .divisor         (divisor_q),
    .partial_rem_out (cell_rem),
    .quotient_bit    (cell_qbit)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      dividend_q <= '0;
      divisor_q  <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dividend_q <= dividend_d;
      divisor_q  <= divisor_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      div_zero_q <= div_zero_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dividend_d = dividend_q;
    divisor_d  = divisor_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    div_zero_d = div_zero_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          dividend_d = dividend;
          divisor_d  = divisor;
          div_zero_d = (divisor == '0);
          rem_d      = '0;
          quo_d      = '0;
          cnt_d      = CntW'(DIV_STEPS - 1);
          state_d    = RUN;
`ifdef DIV_ZERO_FASTPATH_EN
          // Preload the known zero-divisor result; one RUN cycle then DONE.
          if (divisor == '0) begin
            quo_d = '1;
            rem_d = dividend;
            cnt_d = '0;
          end
`endif
        end
      end

      RUN: begin
`ifdef DIV_ZERO_FASTPATH_EN
        if (!div_zero_q) begin
          rem_d = cell_rem;
          quo_d = {quo_q[WIDTH-2:0], cell_qbit};
        end
`else
        rem_d = cell_rem;
        quo_d = {quo_q[WIDTH-2:0], cell_qbit};
`endif
        cnt_d = cnt_q - CntW'(1);
        if (cnt_q == '0) begin
          state_d = DONE;
        end
      end

      DONE: begin
        // Returning to IDLE here never accepts in the same cycle.
        if (out_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == RUN) || (state_q == DONE);
  assign quotient  = quo_q;
  assign remainder = rem_q;
  assign div_zero  = div_zero_q;

endmodule

// File: tb/tb_divider_seq_ctrl.sv
// Scoreboard bench for divider_seq_ctrl: stimulus pushes expected results,
// a negedge monitor pops and compares on every output handshake.

module tb_divider_seq_ctrl;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] dividend;
  logic [3:0] divisor;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] quotient;
  logic [3:0] remainder;
  logic       div_zero;
  logic       busy;

  divider_seq_ctrl #(
    .WIDTH (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dividend  (dividend),
    .divisor   (divisor),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotient  (quotient),
    .remainder (remainder),
    .div_zero  (div_zero),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [3:0] q;
    logic [3:0] r;
    logic       dz;
    string      name;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

`ifdef DIV_ZERO_FASTPATH_EN
  localparam int ZeroLat = 1;
`else
  localparam int ZeroLat = 4;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Monitor: one pop per output handshake.
  always @(negedge clk) begin
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got q=%0d r=%0d dz=%0b, expected no output",
                 quotient, remainder, div_zero);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check({e.name, "_result"}, {23'd0, quotient, remainder, div_zero},
              {23'd0, e.q, e.r, e.dz});
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string name);
    check({name, "_in_ready"}, in_ready, 1);
    check({name, "_out_valid_busy"}, {out_valid, busy}, 0);
    check({name, "_q_r_dz"}, {quotient, remainder, div_zero}, 0);
  endtask

  // Present operands, optionally push expected result, and take the accept edge.
  task automatic drive(input logic [3:0] a, input logic [3:0] b, input bit push,
                       input logic [3:0] q, input logic [3:0] r, input logic dz,
                       input string name, output int acc);
    exp_t e;
    in_valid = 1'b1;
    dividend = a;
    divisor  = b;
    check({name, "_ready_before"}, in_ready, 1);
    if (push) begin
      e.q = q; e.r = r; e.dz = dz; e.name = name;
      exp_q.push_back(e);
    end
    tick();
    acc = cyc;
    check({name, "_accepted"}, {busy, in_ready}, 2'b10);
  endtask

  task automatic wait_valid(input string name, input int acc, input int exp_lat);
    int n;
    n = 0;
    while (out_valid !== 1'b1 && n < 30) begin
      tick();
      n++;
    end
    check({name, "_latency"}, cyc - acc, exp_lat);
  endtask

  task automatic wait_idle(input string name, input int acc, input int exp_ret);
    int n;
    n = 0;
    while (in_ready !== 1'b1 && n < 30) begin
      tick();
      n++;
    end
    if (exp_ret > 0) check({name, "_in_ready_return"}, cyc - acc, exp_ret);
  endtask

  task automatic run_op(input logic [3:0] a, input logic [3:0] b, input logic [3:0] q,
                        input logic [3:0] r, input logic dz, input int lat, input string name);
    int acc;
    drive(a, b, 1'b1, q, r, dz, name, acc);
    in_valid = 1'b0;
    wait_valid(name, acc, lat);
    wait_idle(name, acc, lat + 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int acc;
    int n;
    bit seen;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    dividend  = 4'd0;
    divisor   = 4'd0;
    tick();
    tick();
    check_reset_vals("reset");
    rst_n = 1'b1;
    tick();

    // 13 / 3: latency 4, in_ready low for 5 cycles.
    run_op(4'd13, 4'd3, 4'd4, 4'd1, 1'b0, 4, "d13_3");
    run_op(4'd9, 4'd12, 4'd0, 4'd9, 1'b0, 4, "d9_12");
    run_op(4'd15, 4'd1, 4'd15, 4'd0, 1'b0, 4, "d15_1");
    run_op(4'd7, 4'd0, 4'd15, 4'd7, 1'b1, ZeroLat, "d7_0");
    tick();

    // 10 / 4 with backpressure for 3 cycles and a stray in_valid pulse.
    out_ready = 1'b0;
    drive(4'd10, 4'd4, 1'b1, 4'd2, 4'd2, 1'b0, "stall", acc);
    in_valid = 1'b0;
    wait_valid("stall", acc, 4);
    for (int k = 0; k < 3; k++) begin
      check("stall_hold_flags", {out_valid, in_ready}, 2'b10);
      check("stall_hold_data", {quotient, remainder}, {4'd2, 4'd2});
      in_valid = (k == 1);
      dividend = 4'd1;
      divisor  = 4'd1;
      tick();
    end
    in_valid = 1'b0;
    check("stall_still_valid", out_valid, 1);
    out_ready = 1'b1;
    tick();
    check("stall_released", {out_valid, in_ready, busy}, 3'b010);
    tick();
    tick();
    check("stall_pulse_ignored", {out_valid, busy}, 0);

    // Reset during the second RUN cycle of 11 / 2.
    drive(4'd11, 4'd2, 1'b0, 4'd0, 4'd0, 1'b0, "rst_mid", acc);
    in_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    check_reset_vals("rst_mid");
    rst_n = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (out_valid === 1'b1) seen = 1'b1;
      tick();
    end
    check("rst_mid_no_out_valid", seen, 0);
    run_op(4'd11, 4'd2, 4'd5, 4'd1, 1'b0, 4, "d11_2");

    // Back-to-back with in_valid held continuously.
    drive(4'd15, 4'd15, 1'b1, 4'd1, 4'd0, 1'b0, "b2b_first", acc);
    dividend = 4'd0;
    divisor  = 4'd5;
    exp_q.push_back('{q: 4'd0, r: 4'd0, dz: 1'b0, name: "b2b_second"});
    wait_idle("b2b_first", acc, 5);
    tick();
    check("b2b_second_accept", {busy, in_ready}, 2'b10);
    acc = cyc;
    in_valid = 1'b0;
    wait_valid("b2b_second", acc, 4);
    wait_idle("b2b_second", acc, 5);

    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      tick();
      n++;
    end
    check("scoreboard_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
